// File: rtl/reg_bank_v2_pkg.sv
// Shared encodings and default constants for the banked register file
// and its user/privileged mode controller.
package reg_bank_v2_pkg;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_WR_RES  = 3'd1,
    OP_STK_RST = 3'd2,
    OP_WR_MEM  = 3'd3,
    OP_TRAP    = 3'd4,
    OP_RET     = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    MODE_USER   = 2'd0,
    MODE_ENTER  = 2'd1,
    MODE_PRIV   = 2'd2,
    MODE_RETURN = 2'd3
  } mode_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_N  = 16;
  localparam int DEF_PC_IDX = 15;
  localparam int DEF_SP_IDX = 14;
  localparam int DEF_LR_IDX = 13;

  localparam logic [31:0] DEF_PC_RST    = 32'h0000_0001;
  localparam logic [31:0] DEF_SP_RST    = 32'hFFFF_FFFF;
  localparam logic [31:0] DEF_DATA_BASE = 32'h0000_0190;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0004;

  function automatic logic is_write_op(input logic [2:0] op);
    return (op == OP_WR_RES) || (op == OP_WR_MEM);
  endfunction

endpackage

// File: rtl/reg_bank_mode_fsm.sv
// User/privileged mode sequencer: USER -> ENTER -> PRIV -> RETURN -> USER,
// with one busy cycle on each transition and strobes for the datapath.
module reg_bank_mode_fsm
  import reg_bank_v2_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_enable,
  input  logic [2:0] i_op,
  output logic       o_priv,
  output logic       o_busy,
  output logic       o_enter_start,
  output logic       o_enter_done,
  output logic       o_ret_start
);

  mode_e r_state;
  mode_e w_state_next;

  // Mode state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= MODE_USER;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode, mode flags and transition strobes
  always_comb begin
    w_state_next  = r_state;
    o_priv        = 1'b0;
    o_busy        = 1'b0;
    o_enter_start = 1'b0;
    o_enter_done  = 1'b0;
    o_ret_start   = 1'b0;
    case (r_state)
      MODE_USER: begin
        if (i_enable && (i_op == OP_TRAP)) begin
          w_state_next  = MODE_ENTER;
          o_enter_start = 1'b1;
        end else begin
          w_state_next = MODE_USER;
        end
      end
      MODE_ENTER: begin
        o_busy = 1'b1;
        if (i_enable) begin
          w_state_next = MODE_PRIV;
          o_enter_done = 1'b1;
        end else begin
          w_state_next = MODE_ENTER;
        end
      end
      MODE_PRIV: begin
        o_priv = 1'b1;
        if (i_enable && (i_op == OP_RET)) begin
          w_state_next = MODE_RETURN;
          o_ret_start  = 1'b1;
        end else begin
          w_state_next = MODE_PRIV;
        end
      end
      MODE_RETURN: begin
        o_priv = 1'b1;
        o_busy = 1'b1;
        if (i_enable) begin
          w_state_next = MODE_USER;
        end else begin
          w_state_next = MODE_RETURN;
        end
      end
      default: begin
        w_state_next = MODE_USER;
      end
    endcase
  end

endmodule

// File: rtl/reg_bank_v2.sv
// Architectural register bank with banked SP/LR, write-through read bypass
// and a trap entry/return sequence driven by reg_bank_mode_fsm.
module reg_bank_v2
  import reg_bank_v2_pkg::*;
#(
  parameter int                 DATA_W    = DEF_DATA_W,
  parameter int                 REG_N     = DEF_REG_N,
  parameter int                 PC_IDX    = DEF_PC_IDX,
  parameter int                 SP_IDX    = DEF_SP_IDX,
  parameter int                 LR_IDX    = DEF_LR_IDX,
  parameter logic [DATA_W-1:0]  PC_RST    = DATA_W'(DEF_PC_RST),
  parameter logic [DATA_W-1:0]  SP_RST    = {DATA_W{1'b1}},
  parameter logic [DATA_W-1:0]  DATA_BASE = DATA_W'(DEF_DATA_BASE),
  parameter logic [DATA_W-1:0]  TRAP_VEC  = DATA_W'(DEF_TRAP_VEC),
  localparam int                IDX_W     = $clog2(REG_N)
)(
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        op,
  input  logic [IDX_W-1:0]  rd_d,
  input  logic [IDX_W-1:0]  rd_a,
  input  logic [IDX_W-1:0]  rd_b,
  input  logic [DATA_W-1:0] result_i,
  input  logic [DATA_W-1:0] mem_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] sp_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [DATA_W-1:0] d_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] sp_o,
  output logic [DATA_W-1:0] lr_o,
  output logic              priv_o,
  output logic              busy_o
);

  localparam logic [IDX_W-1:0] L_PC = IDX_W'(PC_IDX);
  localparam logic [IDX_W-1:0] L_SP = IDX_W'(SP_IDX);
  localparam logic [IDX_W-1:0] L_LR = IDX_W'(LR_IDX);

  logic [DATA_W-1:0] r_pc, r_usp, r_psp, r_ulr, r_plr;
  logic [DATA_W-1:0] w_bank [REG_N];
  logic [DATA_W-1:0] w_view [REG_N];
  logic [DATA_W-1:0] w_act_sp, w_act_lr, w_wr_data, w_sp_next;
  logic              w_priv, w_busy, w_enter_start, w_enter_done, w_ret_start;
  logic              w_adv, w_wr_en, w_lr_wr, w_stk_rst;

  reg_bank_mode_fsm u_mode_fsm (
    .clock         (clock),
    .reset         (reset),
    .i_enable      (enable),
    .i_op          (op),
    .o_priv        (w_priv),
    .o_busy        (w_busy),
    .o_enter_start (w_enter_start),
    .o_enter_done  (w_enter_done),
    .o_ret_start   (w_ret_start)
  );

  // PC and SP writes are silently dropped; LR writes are legal and land in the active copy
  assign w_adv     = enable & ~w_busy;
  assign w_wr_en   = w_adv & is_write_op(op) & (rd_d != L_PC) & (rd_d != L_SP);
  assign w_lr_wr   = w_wr_en & (rd_d == L_LR);
  assign w_stk_rst = w_adv & (op == OP_STK_RST);
  assign w_wr_data = (op == OP_WR_MEM) ? mem_i : result_i;
  assign w_sp_next = w_stk_rst ? SP_RST : sp_i;
  assign w_act_sp  = w_priv ? r_psp : r_usp;
  assign w_act_lr  = w_priv ? r_plr : r_ulr;

  for (genvar g = 0; g < REG_N; g++) begin : g_bank
    if ((g == PC_IDX) || (g == SP_IDX) || (g == LR_IDX)) begin : g_alias
      assign w_bank[g] = '0;
    end else begin : g_reg
      logic [DATA_W-1:0] r_q;
      // General-purpose register entry; R0 also takes the data-start value on op 2
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_q <= (g == 0) ? DATA_BASE : '0;
        end else if (w_wr_en && (rd_d == IDX_W'(g))) begin
          r_q <= w_wr_data;
        end else if (w_stk_rst && (g == 0)) begin
          r_q <= DATA_BASE;
        end
      end
      assign w_bank[g] = r_q;
    end
  end

  // Program counter: trap vector on entry, saved PLR on return, else pc_i
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc <= PC_RST;
    end else if (w_enter_done) begin
      r_pc <= TRAP_VEC;
    end else if (w_ret_start) begin
      r_pc <= r_plr;
    end else if (w_adv) begin
      r_pc <= pc_i;
    end
  end

  // Banked stack pointers: only the active copy follows sp_i / stack reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_usp <= SP_RST;
      r_psp <= SP_RST;
    end else if (w_adv && w_priv) begin
      r_psp <= w_sp_next;
    end else if (w_adv) begin
      r_usp <= w_sp_next;
    end
  end

  // Banked link registers; PLR captures the return PC at trap entry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ulr <= '0;
      r_plr <= '0;
    end else if (w_enter_start) begin
      r_plr <= pc_i;
    end else if (w_lr_wr && w_priv) begin
      r_plr <= w_wr_data;
    end else if (w_lr_wr) begin
      r_ulr <= w_wr_data;
    end
  end

  // Architectural view of the bank with PC and active SP/LR overlaid
  always_comb begin
    for (int i = 0; i < REG_N; i++) begin
      w_view[i] = w_bank[i];
    end
    w_view[PC_IDX] = r_pc;
    w_view[SP_IDX] = w_act_sp;
    w_view[LR_IDX] = w_act_lr;
  end

  assign a_o    = (w_wr_en && (rd_a == rd_d)) ? w_wr_data : w_view[rd_a];
  assign b_o    = (w_wr_en && (rd_b == rd_d)) ? w_wr_data : w_view[rd_b];
  assign d_o    = w_wr_en ? w_wr_data : w_view[rd_d];
  assign pc_o   = r_pc;
  assign sp_o   = w_act_sp;
  assign lr_o   = w_act_lr;
  assign priv_o = w_priv;
  assign busy_o = w_busy;

endmodule

// File: tb/tb_reg_bank_v2.sv
// Self-checking bench for reg_bank_v2: reset, bypass, protected indices,
// trap entry/return, stack reset, reset mid-transition, back-to-back writes.
module tb_reg_bank_v2;

  logic        clock = 1'b0;
  logic        reset, enable;
  logic [2:0]  op;
  logic [3:0]  rd_d, rd_a, rd_b;
  logic [31:0] result_i, mem_i, pc_i, sp_i;
  logic [31:0] a_o, b_o, d_o, pc_o, sp_o, lr_o;
  logic        priv_o, busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  reg_bank_v2 dut (
    .clock(clock), .reset(reset), .enable(enable), .op(op),
    .rd_d(rd_d), .rd_a(rd_a), .rd_b(rd_b),
    .result_i(result_i), .mem_i(mem_i), .pc_i(pc_i), .sp_i(sp_i),
    .a_o(a_o), .b_o(b_o), .d_o(d_o), .pc_o(pc_o), .sp_o(sp_o), .lr_o(lr_o),
    .priv_o(priv_o), .busy_o(busy_o)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; op = 3'd0; rd_d = 4'd0; rd_a = 4'd0; rd_b = 4'd7;
    result_i = 32'h0; mem_i = 32'h0; pc_i = 32'h1; sp_i = 32'hFFFF_FFFF;
    #3;
    n_tests++; if (pc_o !== 32'h1) begin n_fail++; $display("FAIL rst_pc: got %h want %h", pc_o, 32'h1); end
    n_tests++; if (sp_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_sp: got %h want %h", sp_o, 32'hFFFF_FFFF); end
    n_tests++; if (a_o !== 32'h190) begin n_fail++; $display("FAIL rst_r0: got %h want %h", a_o, 32'h190); end
    n_tests++; if (b_o !== 32'h0) begin n_fail++; $display("FAIL rst_r7: got %h want %h", b_o, 32'h0); end
    n_tests++; if (lr_o !== 32'h0) begin n_fail++; $display("FAIL rst_lr: got %h want %h", lr_o, 32'h0); end
    n_tests++; if ({priv_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL rst_mode: got %b want %b", {priv_o, busy_o}, 2'b00); end
    cyc();
    reset = 1'b0; enable = 1'b1;
  endtask

  task automatic test_write_bypass();
    op = 3'd1; rd_d = 4'd3; result_i = 32'hDEAD_BEEF; rd_a = 4'd3; rd_b = 4'd5;
    #1;
    n_tests++; if (a_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL byp_a: got %h want %h", a_o, 32'hDEAD_BEEF); end
    n_tests++; if (b_o !== 32'h0) begin n_fail++; $display("FAIL byp_b_nomatch: got %h want %h", b_o, 32'h0); end
    cyc();
    op = 3'd0; #1;
    n_tests++; if (a_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bank_r3: got %h want %h", a_o, 32'hDEAD_BEEF); end
    n_tests++; if (d_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL d_r3: got %h want %h", d_o, 32'hDEAD_BEEF); end
    op = 3'd3; rd_d = 4'd4; mem_i = 32'h1234_5678; result_i = 32'h0; rd_a = 4'd4;
    #1;
    n_tests++; if (a_o !== 32'h1234_5678) begin n_fail++; $display("FAIL byp_mem: got %h want %h", a_o, 32'h1234_5678); end
    cyc();
    op = 3'd0; #1;
    n_tests++; if (a_o !== 32'h1234_5678) begin n_fail++; $display("FAIL bank_r4: got %h want %h", a_o, 32'h1234_5678); end
    enable = 1'b0; op = 3'd1; rd_d = 4'd6; result_i = 32'hFFFF; rd_a = 4'd6;
    #1;
    n_tests++; if (a_o !== 32'h0) begin n_fail++; $display("FAIL nobyp_disabled: got %h want %h", a_o, 32'h0); end
    cyc();
    enable = 1'b1; op = 3'd0; #1;
    n_tests++; if (a_o !== 32'h0) begin n_fail++; $display("FAIL hold_disabled: got %h want %h", a_o, 32'h0); end
  endtask

  task automatic test_protected_writes();
    op = 3'd1; rd_d = 4'd15; result_i = 32'h55; rd_a = 4'd15; pc_i = 32'h200; sp_i = 32'h300;
    #1;
    n_tests++; if (a_o !== 32'h1) begin n_fail++; $display("FAIL pc_nobyp: got %h want %h", a_o, 32'h1); end
    cyc();
    n_tests++; if (pc_o !== 32'h200) begin n_fail++; $display("FAIL pc_follow: got %h want %h", pc_o, 32'h200); end
    n_tests++; if (sp_o !== 32'h300) begin n_fail++; $display("FAIL sp_follow: got %h want %h", sp_o, 32'h300); end
    rd_d = 4'd14; rd_a = 4'd14; pc_i = 32'h204; sp_i = 32'h304;
    #1;
    n_tests++; if (a_o !== 32'h300) begin n_fail++; $display("FAIL sp_nobyp: got %h want %h", a_o, 32'h300); end
    cyc();
    n_tests++; if (pc_o !== 32'h204) begin n_fail++; $display("FAIL pc_follow2: got %h want %h", pc_o, 32'h204); end
    n_tests++; if (sp_o !== 32'h304) begin n_fail++; $display("FAIL sp_follow2: got %h want %h", sp_o, 32'h304); end
    rd_d = 4'd13; rd_a = 4'd13; result_i = 32'hAAAA;
    cyc();
    op = 3'd0; #1;
    n_tests++; if (lr_o !== 32'hAAAA) begin n_fail++; $display("FAIL ulr_write: got %h want %h", lr_o, 32'hAAAA); end
    n_tests++; if (a_o !== 32'hAAAA) begin n_fail++; $display("FAIL ulr_read: got %h want %h", a_o, 32'hAAAA); end
  endtask

  task automatic test_trap_cycle();
    op = 3'd4; pc_i = 32'h100; sp_i = 32'h1000;
    cyc();
    n_tests++; if ({priv_o, busy_o} !== 2'b01) begin n_fail++; $display("FAIL enter_mode: got %b want %b", {priv_o, busy_o}, 2'b01); end
    enable = 1'b0; op = 3'd1; rd_d = 4'd2; result_i = 32'hBAD; pc_i = 32'h999; sp_i = 32'h999; rd_a = 4'd2; rd_b = 4'd2;
    #1;
    n_tests++; if (a_o !== 32'h0) begin n_fail++; $display("FAIL enter_nobyp: got %h want %h", a_o, 32'h0); end
    cyc();
    n_tests++; if ({priv_o, busy_o} !== 2'b01) begin n_fail++; $display("FAIL enter_stall: got %b want %b", {priv_o, busy_o}, 2'b01); end
    enable = 1'b1;
    cyc();
    op = 3'd0; pc_i = 32'h8; sp_i = 32'h80; rd_a = 4'd13;
    #1;
    n_tests++; if (pc_o !== 32'h4) begin n_fail++; $display("FAIL priv_pc: got %h want %h", pc_o, 32'h4); end
    n_tests++; if ({priv_o, busy_o} !== 2'b10) begin n_fail++; $display("FAIL priv_mode: got %b want %b", {priv_o, busy_o}, 2'b10); end
    n_tests++; if (lr_o !== 32'h100) begin n_fail++; $display("FAIL plr_saved: got %h want %h", lr_o, 32'h100); end
    n_tests++; if (a_o !== 32'h100) begin n_fail++; $display("FAIL plr_read: got %h want %h", a_o, 32'h100); end
    n_tests++; if (sp_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL psp_rst: got %h want %h", sp_o, 32'hFFFF_FFFF); end
    n_tests++; if (b_o !== 32'h0) begin n_fail++; $display("FAIL busy_nowrite: got %h want %h", b_o, 32'h0); end
    cyc();
    n_tests++; if (sp_o !== 32'h80) begin n_fail++; $display("FAIL psp_follow: got %h want %h", sp_o, 32'h80); end
    n_tests++; if (pc_o !== 32'h8) begin n_fail++; $display("FAIL priv_pc_follow: got %h want %h", pc_o, 32'h8); end
    op = 3'd4;
    cyc();
    op = 3'd0; #1;
    n_tests++; if ({priv_o, busy_o} !== 2'b10) begin n_fail++; $display("FAIL no_nest: got %b want %b", {priv_o, busy_o}, 2'b10); end
    op = 3'd5;
    cyc();
    op = 3'd1; rd_d = 4'd2; result_i = 32'hBAD; pc_i = 32'h777; sp_i = 32'h777;
    #1;
    n_tests++; if ({priv_o, busy_o} !== 2'b11) begin n_fail++; $display("FAIL ret_mode: got %b want %b", {priv_o, busy_o}, 2'b11); end
    n_tests++; if (pc_o !== 32'h100) begin n_fail++; $display("FAIL ret_pc: got %h want %h", pc_o, 32'h100); end
    n_tests++; if (sp_o !== 32'h80) begin n_fail++; $display("FAIL ret_psp: got %h want %h", sp_o, 32'h80); end
    n_tests++; if (b_o !== 32'h0) begin n_fail++; $display("FAIL ret_nobyp: got %h want %h", b_o, 32'h0); end
    cyc();
    op = 3'd0; pc_i = 32'h100; sp_i = 32'h1000;
    #1;
    n_tests++; if ({priv_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL user_mode: got %b want %b", {priv_o, busy_o}, 2'b00); end
    n_tests++; if (pc_o !== 32'h100) begin n_fail++; $display("FAIL user_pc: got %h want %h", pc_o, 32'h100); end
    n_tests++; if (sp_o !== 32'h1000) begin n_fail++; $display("FAIL usp_kept: got %h want %h", sp_o, 32'h1000); end
    n_tests++; if (lr_o !== 32'hAAAA) begin n_fail++; $display("FAIL ulr_kept: got %h want %h", lr_o, 32'hAAAA); end
  endtask

  task automatic test_stack_reset();
    op = 3'd4;
    cyc();
    op = 3'd0;
    cyc();
    op = 3'd1; rd_d = 4'd0; result_i = 32'h77; sp_i = 32'h80;
    cyc();
    op = 3'd0; rd_a = 4'd0; #1;
    n_tests++; if (a_o !== 32'h77) begin n_fail++; $display("FAIL r0_write: got %h want %h", a_o, 32'h77); end
    op = 3'd2;
    cyc();
    op = 3'd5; sp_i = 32'hFFFF_FFFF; #1;
    n_tests++; if (a_o !== 32'h190) begin n_fail++; $display("FAIL op2_r0: got %h want %h", a_o, 32'h190); end
    n_tests++; if (sp_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL op2_psp: got %h want %h", sp_o, 32'hFFFF_FFFF); end
    n_tests++; if (priv_o !== 1'b1) begin n_fail++; $display("FAIL op2_priv: got %b want %b", priv_o, 1'b1); end
    cyc();
    op = 3'd0;
    cyc();
    sp_i = 32'h1000; #1;
    n_tests++; if (sp_o !== 32'h1000) begin n_fail++; $display("FAIL op2_usp_kept: got %h want %h", sp_o, 32'h1000); end
    op = 3'd5;
    cyc();
    op = 3'd0; #1;
    n_tests++; if ({priv_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL ret_in_user: got %b want %b", {priv_o, busy_o}, 2'b00); end
  endtask

  task automatic test_reset_mid();
    op = 3'd4;
    cyc();
    n_tests++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL mid_enter: got %b want %b", busy_o, 1'b1); end
    #2;
    reset = 1'b1; op = 3'd0; rd_a = 4'd0; rd_b = 4'd3; rd_d = 4'd4;
    #1;
    n_tests++; if ({priv_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL mid_mode: got %b want %b", {priv_o, busy_o}, 2'b00); end
    n_tests++; if (pc_o !== 32'h1) begin n_fail++; $display("FAIL mid_pc: got %h want %h", pc_o, 32'h1); end
    n_tests++; if (sp_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mid_sp: got %h want %h", sp_o, 32'hFFFF_FFFF); end
    n_tests++; if (a_o !== 32'h190) begin n_fail++; $display("FAIL mid_r0: got %h want %h", a_o, 32'h190); end
    n_tests++; if (b_o !== 32'h0) begin n_fail++; $display("FAIL mid_r3: got %h want %h", b_o, 32'h0); end
    n_tests++; if (d_o !== 32'h0) begin n_fail++; $display("FAIL mid_r4: got %h want %h", d_o, 32'h0); end
    n_tests++; if (lr_o !== 32'h0) begin n_fail++; $display("FAIL mid_lr: got %h want %h", lr_o, 32'h0); end
    cyc();
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_hold: got %b want %b", busy_o, 1'b0); end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    wr_t cur, prev;
    logic [31:0] exp_v;
    cur = '{idx: 4'd0, data: 32'h0};
    for (int k = 0; k <= 12; k++) begin
      if (k < 12) begin
        cur.idx  = 4'($urandom_range(0, 3));
        cur.data = $urandom;
        op       = (k % 2 == 1) ? 3'd3 : 3'd1;
        rd_d     = cur.idx;
        mem_i    = (op == 3'd3) ? cur.data : ~cur.data;
        result_i = (op == 3'd1) ? cur.data : ~cur.data;
        sb.push_back(cur);
      end else begin
        op = 3'd0;
      end
      if (k > 0) begin
        prev  = sb.pop_front();
        rd_a  = prev.idx;
        exp_v = ((k < 12) && (cur.idx == prev.idx)) ? cur.data : prev.data;
        #1;
        n_tests++; if (a_o !== exp_v) begin n_fail++; $display("FAIL b2b_r%0d: got %h want %h", prev.idx, a_o, exp_v); end
      end else begin
        #1;
      end
      cyc();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_bypass();
    test_protected_writes();
    test_trap_cycle();
    test_stack_reset();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_v2.md
REG_BANK_V2 -- requirements
Module: reg_bank_v2

Interface
REQ-001 Parameter DATA_W, 32, register width in bits.
REQ-002 Parameter REG_N, 16, number of architectural registers; IDX_W = clog2(REG_N).
REQ-003 Parameter PC_IDX, 15, program counter index; SP_IDX, 14, stack pointer index; LR_IDX, 13, link register index.
REQ-004 Parameter PC_RST, 1, PC reset value; SP_RST, all ones, reset value of both stack pointers; DATA_BASE, 0x190, data-start value for R0; TRAP_VEC, 0x4, privileged entry PC.
REQ-005 clock  in  1  clock; reset reset, asynchronous, active-high; clock clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 enable  in  1  global advance; when low all state holds.
REQ-008 op  in  3  0 none, 1 RD=result, 2 stack/data reset, 3 RD=mem, 4 trap entry, 5 trap return, 6-7 none.
REQ-009 rd_d, rd_a, rd_b  in  IDX_W each  destination/store index and two read indices.
REQ-010 result_i, mem_i, pc_i, sp_i  in  DATA_W each  ALU result, memory load data, next PC, next SP.
REQ-011 a_o, b_o, d_o  out  DATA_W each  read data for rd_a, rd_b, rd_d (d_o feeds store data).
REQ-012 pc_o, sp_o, lr_o  out  DATA_W each  current PC, active-mode SP, active-mode LR.
REQ-013 priv_o  out  1  1 = privileged mode; busy_o  out  1  mode transition in progress.

Function
REQ-014 Reads SHALL be combinational; index SP_IDX returns active SP, LR_IDX returns active LR, others the bank entry.
REQ-015 Read ports SHALL bypass: when op in {1,3}, enable high, not busy, and read index equals legal rd_d, output the write data this cycle.
REQ-016 SP and LR SHALL be banked: USP/ULR for user, PSP/PLR for privileged; active copy selected by priv_o.
REQ-017 Ops 1/3 SHALL write result_i/mem_i to rd_d on enable edge; writes to PC_IDX or SP_IDX SHALL be dropped; writes to LR_IDX SHALL go to the active LR.
REQ-018 Op 2 SHALL load R0 with DATA_BASE and active SP with SP_RST; inactive SP unchanged.
REQ-019 Every other enabled, non-busy cycle SHALL load PC from pc_i and active SP from sp_i; inactive SP held.
REQ-020 FSM states USER, ENTER, PRIV, RETURN; reset state USER.
REQ-021 USER + op 4 + enable -> ENTER: PLR <= pc_i; busy_o=1 in ENTER.
REQ-022 ENTER + enable -> PRIV: PC <= TRAP_VEC, priv_o=1.
REQ-023 PRIV + op 5 + enable -> RETURN: PC <= PLR; busy_o=1 in RETURN.
REQ-024 RETURN + enable -> USER: priv_o=0, PC and USP unchanged.
REQ-025 op 4 in PRIV and op 5 in USER SHALL behave as op 0 (no nesting).
REQ-026 In ENTER/RETURN all op inputs, pc_i and sp_i SHALL be ignored; with enable low the FSM SHALL stall in place.
REQ-027 priv_o SHALL be 1 in PRIV and RETURN, 0 in USER and ENTER.

Reset
REQ-028 Reset SHALL set R0=DATA_BASE, PC=PC_RST, USP=PSP=SP_RST, ULR=PLR=0, other registers 0, FSM=USER, priv_o=0, busy_o=0.
REQ-029 Reset asserted mid-transition SHALL abort to USER immediately, overriding enable.

Structure
REQ-030 Op encodings, FSM state encoding and default index constants SHALL live in the shared package.
REQ-031 The mode FSM SHALL be one sub-module, reg_bank_mode_fsm, outputting priv, busy and state-transition strobes.

Verification
REQ-032 Reset -> pc_o=1, sp_o=0xFFFFFFFF, a_o with rd_a=0 = 0x190, priv_o=0.
REQ-033 op1, rd_d=3, result_i=0xDEADBEEF, rd_a=3 same cycle -> a_o=0xDEADBEEF combinationally; next cycle bank R3=0xDEADBEEF.
REQ-034 op1 rd_d=15 result 0x55 and rd_d=14 -> PC follows pc_i, SP follows sp_i, no corruption.
REQ-035 pc_i=0x100, op4 -> ENTER busy=1, PLR=0x100; next -> PRIV, pc_o=0x4; sp_i=0x80 -> PSP=0x80, USP unchanged; op5 -> RETURN then USER, pc_o=0x100, sp_o=prior USP.
REQ-036 In PRIV op2 -> R0=0x190, PSP=0xFFFFFFFF, USP unchanged; op5 in USER -> no mode change.
REQ-037 Reset pulsed during ENTER -> USER, priv_o=0, busy_o=0, all reset values restored.
